// File: rtl/io_input_conditioner.sv
// ============================================================================
// io_input_conditioner : sync + debounce of SW/KEY pins, key press/release/sticky
// Rev 1.0
// ============================================================================
`default_nettype none

module io_input_conditioner #(
    parameter int N_SW     = 10,
    parameter int N_KEY    = 4,
    parameter int TICK_DIV = 250,
    parameter int DB_TICKS = 400
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_SW-1:0]  i_sw_raw,
    input  logic [N_KEY-1:0] i_key_n_raw,
    input  logic [N_KEY-1:0] i_sticky_clr,
    output logic [N_SW-1:0]  o_sw_db,
    output logic [N_KEY-1:0] o_key_db,
    output logic [N_KEY-1:0] o_key_press,
    output logic [N_KEY-1:0] o_key_release,
    output logic [N_KEY-1:0] o_key_sticky,
    output logic [31:0]      o_io_sw
);

    localparam int NCH = N_SW + N_KEY;
    localparam int CW  = $clog2(DB_TICKS + 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_t;

    logic [N_SW-1:0]  sw_s1, sw_s2;
    logic [N_KEY-1:0] key_s1, key_s2;
    logic [NCH-1:0]   sync_lvl;
    logic [NCH-1:0]   db, db_nxt;
    logic             tick;

    // Keys idle high at the pin, so their synchronisers reset to the released level
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= i_sw_raw;
            sw_s2  <= sw_s1;
            key_s1 <= i_key_n_raw;
            key_s2 <= key_s1;
        end
    end

    assign sync_lvl = {~key_s2, sw_s2};

    generate
        if (TICK_DIV == 1) begin : g_tick_const
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] pre;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    pre <= '0;
                end else if (pre == PW'(TICK_DIV - 1)) begin
                    pre <= '0;
                end else begin
                    pre <= pre + 1'b1;
                end
            end

            assign tick = (pre == PW'(TICK_DIV - 1));
        end
    endgenerate

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            ch_state_t     state;
            logic [CW-1:0] cnt, cnt_nxt;
            logic          db_n;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end

            always_comb begin
                state   = (sync_lvl[i] == db[i]) ? STABLE : PENDING;
                cnt_nxt = '0;
                db_n    = db[i];
                case (state)
                    STABLE: cnt_nxt = '0;
                    PENDING: begin
                        cnt_nxt = cnt;
                        if (tick) begin
                            // Accept on the tick that would complete DB_TICKS
                            if (cnt == CW'(DB_TICKS - 1)) begin
                                db_n    = ~db[i];
                                cnt_nxt = '0;
                            end else begin
                                cnt_nxt = cnt + 1'b1;
                            end
                        end
                    end
                    default: cnt_nxt = '0;
                endcase
            end

            assign db_nxt[i] = db_n;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            db            <= '0;
            o_key_press   <= '0;
            o_key_release <= '0;
            o_key_sticky  <= '0;
        end else begin
            db            <= db_nxt;
            o_key_press   <= db_nxt[NCH-1:N_SW] & ~db[NCH-1:N_SW];
            o_key_release <= ~db_nxt[NCH-1:N_SW] & db[NCH-1:N_SW];
            o_key_sticky  <= (o_key_sticky & ~i_sticky_clr) | o_key_press;
        end
    end

    assign o_sw_db  = db[N_SW-1:0];
    assign o_key_db = db[NCH-1:N_SW];

    generate
        if (NCH < 32) begin : g_pad
            assign o_io_sw = {{(32 - NCH){1'b0}}, db};
        end else begin : g_nopad
            assign o_io_sw = db;
        end
    endgenerate

endmodule

`default_nettype wire
